// File: rtl/bitsim_mac_column_seq.sv
// Bit-serial dot-product engine: one activation vector against WEIGHT_BITS
// weight bit-columns. Group sums are computed once per tile. Each column then
// contributes a skip/complement term that is negated on the MSB column,
// shifted by its column index and accumulated. The result is saturated and can
// optionally be max-pooled against a previous result.
module bitsim_mac_column_seq #(
    parameter int DATA_WIDTH    = 8,
    parameter int VEC_LENGTH    = 16,
    parameter int GROUP_SIZE    = 8,
    parameter int NUM_GROUPS    = VEC_LENGTH / GROUP_SIZE,
    parameter int SEL_PER_GROUP = GROUP_SIZE / 2,
    parameter int SEL_WIDTH     = $clog2(GROUP_SIZE) + 1,
    parameter int WEIGHT_BITS   = 8,
    parameter int ACC_WIDTH     = DATA_WIDTH + WEIGHT_BITS + $clog2(VEC_LENGTH),
    parameter int RESULT_WIDTH  = 2 * DATA_WIDTH
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        act_valid,
    output logic                                        act_ready,
    input  logic [VEC_LENGTH*DATA_WIDTH-1:0]            act,
    input  logic                                        acc_init,
    input  logic                                        is_pooling,
    input  logic [RESULT_WIDTH-1:0]                     result_prev,
    input  logic                                        col_valid,
    output logic                                        col_ready,
    input  logic [NUM_GROUPS*SEL_PER_GROUP*SEL_WIDTH-1:0] col_sel,
    input  logic [NUM_GROUPS-1:0]                       col_skip_zero,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [RESULT_WIDTH-1:0]                     result
);

    localparam int GSUM_W = DATA_WIDTH + $clog2(GROUP_SIZE);
    localparam int CNT_W  = (WEIGHT_BITS > 1) ? $clog2(WEIGHT_BITS) : 1;
    localparam int CMP_W  = (ACC_WIDTH > RESULT_WIDTH) ? ACC_WIDTH : RESULT_WIDTH;

    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(WEIGHT_BITS - 1);

    localparam logic signed [CMP_W-1:0] RES_MAX =
        {{(CMP_W-RESULT_WIDTH+1){1'b0}}, {(RESULT_WIDTH-1){1'b1}}};
    localparam logic signed [CMP_W-1:0] RES_MIN =
        {{(CMP_W-RESULT_WIDTH+1){1'b1}}, {(RESULT_WIDTH-1){1'b0}}};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SUMS  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]                       state;
    logic [VEC_LENGTH*DATA_WIDTH-1:0] act_q;
    logic                             pool_q;
    logic signed [RESULT_WIDTH-1:0]   prev_q;
    logic signed [GSUM_W-1:0]         group_sum_q [NUM_GROUPS];
    logic signed [GSUM_W-1:0]         group_sum_d [NUM_GROUPS];
    logic signed [ACC_WIDTH-1:0]      sel_sum     [NUM_GROUPS];
    logic signed [ACC_WIDTH-1:0]      col_term;
    logic [CNT_W-1:0]                 col_cnt;
    logic                             p1_valid;
    logic signed [ACC_WIDTH-1:0]      p1_term;
    logic [CNT_W-1:0]                 p1_tag;
    logic signed [ACC_WIDTH-1:0]      stage2_term;
    logic signed [ACC_WIDTH-1:0]      acc;
    logic signed [CMP_W-1:0]          acc_ext;
    logic signed [RESULT_WIDTH-1:0]   sat_val;
    logic signed [RESULT_WIDTH-1:0]   res_d;
    logic                             col_fire;

    assign act_ready = (state == S_IDLE);
    assign col_ready = (state == S_RUN);
    assign col_fire  = col_valid && (state == S_RUN);

    // Per-group sum of all latched activations, registered in SUMS.
    always_comb begin
        for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
            group_sum_d[g] = '0;
            for (int unsigned i = 0; i < GROUP_SIZE; i++) begin
                group_sum_d[g] = group_sum_d[g] +
                    GSUM_W'($signed(act_q[(g*GROUP_SIZE+i)*DATA_WIDTH +: DATA_WIDTH]));
            end
        end
    end

    // Column term: selected-lane sum per group, or its complement within the group.
    always_comb begin
        int unsigned sel;
        col_term = '0;
        for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
            sel_sum[g] = '0;
            for (int unsigned k = 0; k < SEL_PER_GROUP; k++) begin
                sel = 32'(col_sel[(g*SEL_PER_GROUP+k)*SEL_WIDTH +: SEL_WIDTH]);
                if (sel < GROUP_SIZE) begin
                    sel_sum[g] = sel_sum[g] +
                        ACC_WIDTH'($signed(act_q[(g*GROUP_SIZE+sel)*DATA_WIDTH +: DATA_WIDTH]));
                end
            end
            if (col_skip_zero[g]) begin
                col_term = col_term + sel_sum[g];
            end else begin
                col_term = col_term + ACC_WIDTH'(group_sum_q[g]) - sel_sum[g];
            end
        end
    end

    // Stage 2 weighting: shift by column index, negate the sign column.
    always_comb begin
        stage2_term = p1_term <<< p1_tag;
        if (p1_tag == LAST_COL) begin
            stage2_term = -stage2_term;
        end
    end

    // Output value: saturate the accumulator, then optional max-pool (ties keep prev).
    always_comb begin
        acc_ext = CMP_W'(acc);
        if (acc_ext > RES_MAX) begin
            sat_val = RES_MAX[RESULT_WIDTH-1:0];
        end else if (acc_ext < RES_MIN) begin
            sat_val = RES_MIN[RESULT_WIDTH-1:0];
        end else begin
            sat_val = acc_ext[RESULT_WIDTH-1:0];
        end
        res_d = sat_val;
        if (pool_q && !(sat_val > prev_q)) begin
            res_d = prev_q;
        end
    end

    // Tile sequencer, column pipeline and accumulator.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            act_q     <= '0;
            pool_q    <= 1'b0;
            prev_q    <= '0;
            col_cnt   <= '0;
            p1_valid  <= 1'b0;
            p1_term   <= '0;
            p1_tag    <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
                group_sum_q[g] <= '0;
            end
        end else begin
            p1_valid <= col_fire;
            if (col_fire) begin
                p1_term <= col_term;
                p1_tag  <= col_cnt;
            end
            if (p1_valid) begin
                acc <= acc + stage2_term;
            end
            case (state)
                S_IDLE: begin
                    if (act_valid) begin
                        act_q  <= act;
                        pool_q <= is_pooling;
                        prev_q <= result_prev;
                        acc    <= acc_init ? ACC_WIDTH'($signed(result_prev)) : '0;
                        state  <= S_SUMS;
                    end
                end
                S_SUMS: begin
                    for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
                        group_sum_q[g] <= group_sum_d[g];
                    end
                    col_cnt <= '0;
                    state   <= S_RUN;
                end
                S_RUN: begin
                    if (col_valid) begin
                        col_cnt <= col_cnt + CNT_W'(1);
                        if (col_cnt == LAST_COL) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // An empty stage 1 here means the final add landed on the previous edge.
                    if (!p1_valid) begin
                        result    <= res_d;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bitsim_mac_column_seq.sv
// Scoreboard bench for bitsim_mac_column_seq: expected tile results are queued
// when the activation vector is offered and compared on the output handshake.
module tb_bitsim_mac_column_seq;

    localparam int DW = 8;
    localparam int VL = 16;
    localparam int GS = 8;
    localparam int NG = 2;
    localparam int SPG = 4;
    localparam int SW = 4;
    localparam int WB = 8;
    localparam int RW = 16;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  act_valid;
    logic                  act_ready;
    logic [VL*DW-1:0]      act;
    logic                  acc_init;
    logic                  is_pooling;
    logic [RW-1:0]         result_prev;
    logic                  col_valid;
    logic                  col_ready;
    logic [NG*SPG*SW-1:0]  col_sel;
    logic [NG-1:0]         col_skip_zero;
    logic                  out_valid;
    logic                  out_ready;
    logic [RW-1:0]         result;

    int n_vec  = 0;
    int n_miss = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    bitsim_mac_column_seq #(
        .DATA_WIDTH  (DW),
        .VEC_LENGTH  (VL),
        .GROUP_SIZE  (GS),
        .WEIGHT_BITS (WB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .act_valid     (act_valid),
        .act_ready     (act_ready),
        .act           (act),
        .acc_init      (acc_init),
        .is_pooling    (is_pooling),
        .result_prev   (result_prev),
        .col_valid     (col_valid),
        .col_ready     (col_ready),
        .col_sel       (col_sel),
        .col_skip_zero (col_skip_zero),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result)
    );

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NG*SPG*SW-1:0] sel_vec(input bit zero);
        logic [NG*SPG*SW-1:0] v;
        v = '0;
        for (int j = 0; j < NG*SPG; j++) begin
            v[j*SW +: SW] = zero ? SW'(8) : SW'(j % SPG);
        end
        return v;
    endfunction

    // Output-side scoreboard: compare on every accepted result.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_val("sb_unexpected_output", 0, 1);
            end else begin
                check_val("result", longint'($signed(result)), exp_q.pop_front());
            end
        end
    end

    task automatic run_tile(input logic [VL*DW-1:0] av, input logic [WB-1:0] zero_mask,
                            input logic [WB-1:0] skip_mask, input bit init, input bit pool,
                            input int prev, input bit gap, input int stall,
                            input int abort_after, input int expv);
        int budget;
        budget = 0;
        while (!act_ready && budget < 50) begin
            tick();
            budget++;
        end
        if (!act_ready) check_val("act_ready_timeout", 0, 1);
        act_valid   = 1'b1;
        act         = av;
        acc_init    = init;
        is_pooling  = pool;
        result_prev = RW'(prev);
        if (abort_after < 0) exp_q.push_back(expv);
        tick();
        act_valid = 1'b0;
        act       = '0;
        check_val("act_ready_busy", act_ready, 0);
        for (int c = 0; c < WB; c++) begin
            if (c == abort_after) begin
                col_valid = 1'b0;
                reset     = 1'b1;
                tick();
                reset = 1'b0;
                check_val("abort_act_ready", act_ready, 1);
                check_val("abort_out_valid", out_valid, 0);
                check_val("abort_result", longint'($signed(result)), 0);
                return;
            end
            if (gap && c > 0) begin
                col_valid = 1'b0;
                tick();
                check_val("gap_act_ready", act_ready, 0);
            end
            col_valid     = 1'b1;
            col_sel       = sel_vec(zero_mask[c]);
            col_skip_zero = skip_mask[c] ? '1 : '0;
            budget = 0;
            while (!col_ready && budget < 50) begin
                tick();
                budget++;
            end
            if (!col_ready) check_val("col_ready_timeout", 0, 1);
            tick();
            col_valid = 1'b0;
        end
        check_val("col_ready_drain", col_ready, 0);
        check_val("lat0_out_valid", out_valid, 0);
        tick();
        check_val("lat1_out_valid", out_valid, 0);
        tick();
        check_val("lat2_out_valid", out_valid, 1);
        for (int s = 0; s < stall; s++) begin
            tick();
            check_val("hold_valid", out_valid, 1);
            check_val("hold_result", longint'($signed(result)), expv);
            check_val("hold_act_ready", act_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("post_out_valid", out_valid, 0);
        check_val("post_act_ready", act_ready, 1);
        check_val("post_result_held", longint'($signed(result)), expv);
    endtask

    logic [VL*DW-1:0] ones_v, ramp_v, max_v;

    initial begin
        reset         = 1'b1;
        act_valid     = 1'b0;
        act           = '0;
        acc_init      = 1'b0;
        is_pooling    = 1'b0;
        result_prev   = '0;
        col_valid     = 1'b0;
        col_sel       = '0;
        col_skip_zero = '0;
        out_ready     = 1'b0;
        for (int i = 0; i < VL; i++) begin
            ones_v[i*DW +: DW] = DW'(1);
            ramp_v[i*DW +: DW] = DW'(i);
            max_v[i*DW +: DW]  = DW'(127);
        end
        repeat (3) tick();
        reset = 1'b0;
        check_val("rst_act_ready", act_ready, 1);
        check_val("rst_col_ready", col_ready, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_result", longint'($signed(result)), 0);

        // all ones, selected lanes, MSB column negative
        run_tile(ones_v, 8'h00, 8'hFF, 1'b0, 1'b0, 0, 1'b0, 0, -1, -8);
        // ramp, complement on column 0 only
        run_tile(ramp_v, 8'hFE, 8'hFE, 1'b0, 1'b0, 0, 1'b0, 0, -1, 76);
        // large positive, saturates
        run_tile(max_v, 8'h80, 8'hFF, 1'b0, 1'b0, 0, 1'b0, 0, -1, 32767);
        // pooling keeps the larger previous result
        run_tile(ones_v, 8'h00, 8'hFF, 1'b0, 1'b1, 100, 1'b0, 0, -1, 100);
        // accumulator seeded from previous result
        run_tile(ones_v, 8'h00, 8'hFF, 1'b1, 1'b0, 100, 1'b0, 0, -1, 92);
        // sparse column handshakes and output back-pressure
        run_tile(ones_v, 8'h00, 8'hFF, 1'b0, 1'b0, 0, 1'b1, 5, -1, -8);
        // reset in the middle of a tile
        run_tile(ones_v, 8'h00, 8'hFF, 1'b0, 1'b0, 0, 1'b0, 0, 3, 0);
        run_tile(ones_v, 8'h00, 8'hFF, 1'b0, 1'b0, 0, 1'b0, 0, -1, -8);

        repeat (3) tick();
        check_val("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
